// File: rtl/sram_matrix_loader.sv
// Streams an input matrix and a weight matrix (header word, then row-major
// elements) into two SRAMs, then starts the compute DUT and waits for it to finish.
module sram_matrix_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              input_write_enable,
  output logic [ADDR_W-1:0] input_write_address,
  output logic [DATA_W-1:0] input_write_data,
  output logic              weight_write_enable,
  output logic [ADDR_W-1:0] weight_write_address,
  output logic [DATA_W-1:0] weight_write_data,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic              busy,
  output logic              done,
  output logic              err_oversize
);

  localparam int HALF = DATA_W / 2;
  // Largest element count whose last address (N) still fits below the top address.
  localparam logic [DATA_W-1:0] MAX_N = (DATA_W'(1) << ADDR_W) - DATA_W'(2);

  typedef enum logic [3:0] {
    IDLE, IN_HDR, IN_DATA, WT_HDR, WT_DATA, DRAIN, WAIT_RDY, START, BUSY, DONE
  } state_t;

  state_t state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] count_reg;
  logic              seen_low_reg;

  logic [DATA_W-1:0] n_elems;
  logic              oversize;
  logic              accept;
  logic              is_hdr;
  logic              is_weight;
  logic              last_elem;

  assign n_elems   = {{HALF{1'b0}}, s_data[DATA_W-1:HALF]} * {{HALF{1'b0}}, s_data[HALF-1:0]};
  assign oversize  = n_elems > MAX_N;
  assign accept    = s_ready && s_valid;
  assign is_hdr    = (state_reg == IN_HDR) || (state_reg == WT_HDR);
  assign is_weight = (state_reg == WT_HDR) || (state_reg == WT_DATA);
  assign last_elem = count_reg == ADDR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    busy       = 1'b1;
    dut_valid  = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (load_start) state_next = IN_HDR;
      end
      IN_HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (oversize)          state_next = IDLE;
          else if (n_elems == 0) state_next = WT_HDR;
          else                   state_next = IN_DATA;
        end
      end
      IN_DATA: begin
        s_ready = 1'b1;
        if (s_valid && last_elem) state_next = WT_HDR;
      end
      WT_HDR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (oversize)          state_next = IDLE;
          else if (n_elems == 0) state_next = DRAIN;
          else                   state_next = WT_DATA;
        end
      end
      WT_DATA: begin
        s_ready = 1'b1;
        if (s_valid && last_elem) state_next = DRAIN;
      end
      DRAIN:    state_next = WAIT_RDY;
      WAIT_RDY: if (dut_ready) state_next = START;
      START: begin
        dut_valid  = 1'b1;
        state_next = BUSY;
      end
      // Completion is a low-to-high return of dut_ready after the start pulse.
      BUSY:     if (seen_low_reg && dut_ready) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg             <= '0;
      count_reg            <= '0;
      seen_low_reg         <= 1'b0;
      err_oversize         <= 1'b0;
      input_write_enable   <= 1'b0;
      input_write_address  <= '0;
      input_write_data     <= '0;
      weight_write_enable  <= 1'b0;
      weight_write_address <= '0;
      weight_write_data    <= '0;
    end else begin
      input_write_enable  <= 1'b0;
      weight_write_enable <= 1'b0;
      err_oversize        <= 1'b0;
      if (state_reg == START)                  seen_low_reg <= 1'b0;
      else if (state_reg == BUSY && !dut_ready) seen_low_reg <= 1'b1;
      if (accept) begin
        if (is_hdr && oversize) begin
          err_oversize <= 1'b1;
        end else begin
          if (is_weight) begin
            weight_write_enable  <= 1'b1;
            weight_write_address <= is_hdr ? '0 : addr_reg;
            weight_write_data    <= s_data;
          end else begin
            input_write_enable   <= 1'b1;
            input_write_address  <= is_hdr ? '0 : addr_reg;
            input_write_data     <= s_data;
          end
          if (is_hdr) begin
            addr_reg  <= ADDR_W'(1);
            count_reg <= n_elems[ADDR_W-1:0];
          end else begin
            addr_reg  <= addr_reg + ADDR_W'(1);
            count_reg <= count_reg - ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_matrix_loader.sv
// Scoreboard bench: stimulus pushes expected writes/pulses, a monitor pops them
// as the loader presents write strobes, dut_valid, done and err_oversize.
module tb_sram_matrix_loader;

  localparam int K_IN   = 0;
  localparam int K_WT   = 1;
  localparam int K_VAL  = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        input_write_enable;
  logic [15:0] input_write_address;
  logic [31:0] input_write_data;
  logic        weight_write_enable;
  logic [15:0] weight_write_address;
  logic [31:0] weight_write_data;
  logic        dut_valid;
  logic        dut_ready;
  logic        busy;
  logic        done;
  logic        err_oversize;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   hold_low = 1'b0;

  sram_matrix_loader #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk                  (clk),
    .reset                (rst),
    .load_start           (load_start),
    .s_valid              (s_valid),
    .s_ready              (s_ready),
    .s_data               (s_data),
    .input_write_enable   (input_write_enable),
    .input_write_address  (input_write_address),
    .input_write_data     (input_write_data),
    .weight_write_enable  (weight_write_enable),
    .weight_write_address (weight_write_address),
    .weight_write_data    (weight_write_data),
    .dut_valid            (dut_valid),
    .dut_ready            (dut_ready),
    .busy                 (busy),
    .done                 (done),
    .err_oversize         (err_oversize)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void observe(input int kind, input logic [15:0] a, input logic [31:0] d);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected nothing", kind, a, d);
    end else begin
      e = q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (kind <= K_WT) begin
        chk("write_addr", 64'(a), 64'(e.addr));
        chk("write_data", 64'(d), 64'(e.data));
      end
      $display("event kind=%0d addr=%0h data=%0h", kind, a, d);
    end
  endfunction

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (input_write_enable && weight_write_enable)
          chk("dual_write_enable", 64'(1), 64'(0));
        if (input_write_enable)  observe(K_IN, input_write_address, input_write_data);
        if (weight_write_enable) observe(K_WT, weight_write_address, weight_write_data);
        if (dut_valid) begin
          chk("ready_at_dut_valid", 64'(dut_ready), 64'(1));
          observe(K_VAL, 16'h0, 32'h0);
        end
        if (done)         observe(K_DONE, 16'h0, 32'h0);
        if (err_oversize) observe(K_ERR, 16'h0, 32'h0);
      end
    end
  end

  // Compute-DUT model: drops ready for 10 cycles after each start pulse.
  initial begin
    dut_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (dut_valid) begin
        dut_ready = 1'b0;
        repeat (10) @(negedge clk);
        dut_ready = 1'b1;
      end else begin
        dut_ready = !hold_low;
      end
    end
  end

  task automatic push(input int k, input int a, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = 16'(a);
    e.data = d;
    q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] d, input bit gap);
    int n;
    bit got;
    if (gap) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = d;
    got = 1'b0;
    n = 0;
    while (!got && n < 50) begin
      got = s_ready;
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    if (!got) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] hi, input logic [31:0] hw, input bit gap);
    int ni;
    int nw;
    ni = int'(hi[31:16]) * int'(hi[15:0]);
    nw = int'(hw[31:16]) * int'(hw[15:0]);
    pulse_start();
    push(K_IN, 0, hi);
    send_word(hi, gap);
    for (int i = 0; i < ni; i++) begin
      push(K_IN, i + 1, 32'hA000_0000 + 32'(i));
      send_word(32'hA000_0000 + 32'(i), gap);
    end
    push(K_WT, 0, hw);
    send_word(hw, gap);
    for (int i = 0; i < nw; i++) begin
      push(K_WT, i + 1, 32'hB000_0000 + 32'(i));
      send_word(32'hB000_0000 + 32'(i), gap);
    end
    push(K_VAL, 0, 32'h0);
    push(K_DONE, 0, 32'h0);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("pending_after_wait", 64'(q.size()), 64'(0));
  endtask

  function automatic logic any_output();
    return |{s_ready, input_write_enable, input_write_address, input_write_data,
             weight_write_enable, weight_write_address, weight_write_data,
             dut_valid, busy, done, err_oversize};
  endfunction

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_data     = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(any_output()), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // 2x3 input, 3x2 weight, continuous valid
    run_load(32'h0002_0003, 32'h0003_0002, 1'b0);
    wait_drain(200);
    @(negedge clk);
    chk("idle_after_done", 64'(busy), 64'(0));

    // same load with valid gaps
    run_load(32'h0002_0003, 32'h0003_0002, 1'b1);
    wait_drain(200);
    @(negedge clk);

    // zero-element input matrix: next word is the weight header
    run_load(32'h0000_0004, 32'h0001_0002, 1'b0);
    wait_drain(200);
    @(negedge clk);

    // oversize header rejected
    pulse_start();
    push(K_ERR, 0, 32'h0);
    send_word(32'h0100_0100, 1'b0);
    chk("oversize_s_ready", 64'(s_ready), 64'(0));
    chk("oversize_busy", 64'(busy), 64'(0));
    wait_drain(20);

    // reset after three input elements, then a fresh load
    pulse_start();
    push(K_IN, 0, 32'h0002_0003);
    send_word(32'h0002_0003, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(K_IN, i + 1, 32'hA000_0000 + 32'(i));
      send_word(32'hA000_0000 + 32'(i), 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("midreset_outputs", 64'(any_output()), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_pending", 64'(q.size()), 64'(0));
    @(negedge clk);
    run_load(32'h0001_0001, 32'h0001_0001, 1'b0);
    wait_drain(200);
    @(negedge clk);

    // dut_ready low on reaching WAIT_RDY: start pulse must be withheld
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    run_load(32'h0001_0002, 32'h0002_0001, 1'b0);
    repeat (5) @(negedge clk);
    chk("valid_withheld", 64'(q.size()), 64'(2));
    hold_low = 1'b0;
    wait_drain(200);

    chk("final_queue_empty", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_matrix_loader.md
# sram_matrix_loader

- Writer side of the matrix-multiply SRAM interface.
- Accepts a valid/ready word stream carrying two matrices (input, then weight) and writes each into its SRAM.
- Each matrix is written as a header word at address 0 and row-major elements from address 1.
- Then hands off to the compute DUT with a single `dut_valid` pulse and reports `done` when the DUT's `dut_ready` returns high.

## Interface
- `ADDR_W`, 16, SRAM address width.
- `DATA_W`, 32, SRAM word / stream width; header is {rows[DATA_W-1:DATA_W/2], cols[DATA_W/2-1:0]}.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader can accept a stream word.
- `s_data`  in  DATA_W  stream word (header or element).
- `input_write_enable`  out  1  input SRAM write strobe.
- `input_write_address`  out  ADDR_W  input SRAM write address.
- `input_write_data`  out  DATA_W  input SRAM write data.
- `weight_write_enable`  out  1  weight SRAM write strobe.
- `weight_write_address`  out  ADDR_W  weight SRAM write address.
- `weight_write_data`  out  DATA_W  weight SRAM write data.
- `dut_valid`  out  1  start pulse to compute DUT.
- `dut_ready`  in  1  DUT idle/complete indication.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the DUT finishes.
- `err_oversize`  out  1  one-cycle pulse when a header is rejected.

## Operation
- States: IDLE, IN_HDR, IN_DATA, WT_HDR, WT_DATA, DRAIN, WAIT_RDY, START, BUSY, DONE.
- IDLE: `s_ready`=0. On `load_start`, go to IN_HDR.
- IN_HDR and WT_HDR: `s_ready`=1.
  - On accept, compute N = rows*cols, full DATA_W width.
  - If N > 2^ADDR_W-2: do not write, pulse `err_oversize`, return to IDLE.
  - Otherwise write the header to address 0 and load the element counter with N.
  - If N=0, skip the data state (IN_HDR→WT_HDR, WT_HDR→DRAIN). Otherwise go to IN_DATA / WT_DATA.
- IN_DATA and WT_DATA: `s_ready`=1.
  - Each accepted word is written to the next address, starting at 1.
  - After the Nth accept, advance: IN_DATA→WT_HDR, WT_DATA→DRAIN.
- DRAIN: one cycle, lets the final registered write retire. Then go to WAIT_RDY.
- WAIT_RDY: wait for `dut_ready`=1, then go to START.
- START: `dut_valid`=1 for exactly one cycle, then go to BUSY.
- BUSY: wait for `dut_ready` to fall, then rise again. Go to DONE on the rising sample.
- DONE: `done`=1 for one cycle, then IDLE.
- `load_start` outside IDLE is ignored.
- Address counters are ADDR_W bits. They never wrap, guaranteed by the oversize check.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-operation:
  - Immediate return to IDLE; all strobes drop asynchronously.
  - Partially written SRAM contents are left as-is.
- Write outputs are registered. A word accepted at edge k produces enable/address/data valid for the cycle following edge k; enable is 1 only for that cycle.
- Throughput is one word per cycle. `s_valid` gaps insert no writes and do not change the address.
- `s_ready` is a state decode; it does not depend combinationally on `s_valid`.
- Input and weight write enables are never high in the same cycle.
- Minimum latency from the final weight accept to `dut_valid`: 3 edges (write cycle, DRAIN, START), when `dut_ready` is already high.
- In BUSY, a `dut_ready` that stays high is not a completion; a falling edge must be seen first.

## Test plan
- Input 2x3 (header 0x0002_0003), weight 3x2 (header 0x0003_0002), continuous valid:
  - Input SRAM gets writes at addr 0..6, then weight SRAM at 0..6.
  - `dut_valid` pulses once with `dut_ready` high.
  - DUT drops ready for 10 cycles then raises it → `done` pulses one cycle later.
- Same load with `s_valid` toggling every other cycle → identical addresses/data, one write per accepted word, no duplicate enables.
- Input header 0x0000_0004 → header written at input addr 0, no input data writes, next stream word is treated as the weight header.
- Header 0x0100_0100 with `ADDR_W`=16 → `err_oversize` pulses, no write, state IDLE, `s_ready`=0.
- Reset asserted after 3 input elements → all outputs 0 next sample. A subsequent `load_start` with fresh headers writes starting again at address 0.
- `dut_ready` low on entering WAIT_RDY for 5 cycles → `dut_valid` withheld until ready rises, then a single pulse.
